// File: rtl/ysyx_22040759_exe_mc_pkg.sv
// Shared op-code constants, MDU state encodings and small decode helpers
// for the ysyx_22040759 execute stage.
package ysyx_22040759_exe_mc_pkg;

  typedef logic [4:0] op_t;

  localparam op_t ALU_ADD  = 5'd0;
  localparam op_t ALU_SUB  = 5'd1;
  localparam op_t ALU_AND  = 5'd2;
  localparam op_t ALU_OR   = 5'd3;
  localparam op_t ALU_XOR  = 5'd4;
  localparam op_t ALU_SLL  = 5'd5;
  localparam op_t ALU_SRL  = 5'd6;
  localparam op_t ALU_SRA  = 5'd7;
  localparam op_t ALU_SLT  = 5'd8;
  localparam op_t ALU_SLTU = 5'd9;

  localparam op_t MDU_MUL   = 5'd16;
  localparam op_t MDU_MULHU = 5'd17;
  localparam op_t MDU_DIV   = 5'd18;
  localparam op_t MDU_DIVU  = 5'd19;
  localparam op_t MDU_REM   = 5'd20;
  localparam op_t MDU_REMU  = 5'd21;

  localparam int IS_MDU_BIT = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_mdu(input op_t op);
    return op[IS_MDU_BIT];
  endfunction

  // Ops that work on operand magnitudes and need a sign fixup on the way out.
  function automatic logic mdu_signed(input op_t op);
    return (op == MDU_MUL) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/ysyx_22040759_exe_mc_if.sv
// ID->EXE->MEM stage bus: valid/allowin handshake, operands, sideband,
// flush and forwarding. The stage is the slave; its environment the master.
interface ysyx_22040759_exe_mc_if #(
  parameter int XLEN      = 64,
  parameter int PAYLOAD_W = 128
);
  logic                 flush;
  logic                 ds_to_es_valid;
  logic                 es_allowin;
  logic [4:0]           ds_op;
  logic [XLEN-1:0]      ds_a;
  logic [XLEN-1:0]      ds_b;
  logic [4:0]           ds_rd;
  logic                 ds_reg_wen;
  logic [PAYLOAD_W-1:0] ds_payload;
  logic                 ms_allowin;
  logic                 es_to_ms_valid;
  logic [XLEN-1:0]      es_result;
  logic [PAYLOAD_W-1:0] es_payload;
  logic                 es_fwd_valid;
  logic [4:0]           es_fwd_rd;
  logic [XLEN-1:0]      es_fwd_data;
  logic                 es_busy;

  modport master (
    output flush, ds_to_es_valid, ds_op, ds_a, ds_b, ds_rd, ds_reg_wen,
           ds_payload, ms_allowin,
    input  es_allowin, es_to_ms_valid, es_result, es_payload, es_fwd_valid,
           es_fwd_rd, es_fwd_data, es_busy
  );

  modport slave (
    input  flush, ds_to_es_valid, ds_op, ds_a, ds_b, ds_rd, ds_reg_wen,
           ds_payload, ms_allowin,
    output es_allowin, es_to_ms_valid, es_result, es_payload, es_fwd_valid,
           es_fwd_rd, es_fwd_data, es_busy
  );
endinterface

// File: rtl/ysyx_22040759_iter_mdu.sv
// Iterative multiply/divide unit: XLEN shift-add or restoring-divide steps,
// one per cycle, on operands held stable by the stage wrapper.
//
// state | meaning
// IDLE  | no MDU op in flight
// RUN   | iterating, cnt = index of the step taken this cycle
// DONE  | result final, waiting for the MEM handshake
module ysyx_22040759_iter_mdu
  import ysyx_22040759_exe_mc_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic            ack,
  input  op_t             op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(XLEN);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] p_q, p_in, p_nxt, prod;
  logic [XLEN-1:0]   r_q, q_q, r_in, q_in, r_nxt, q_nxt, r_sub, quo, rem;
  logic [XLEN:0]     psum, r_sh;
  logic [XLEN-1:0]   ma, mb;
  logic              neg_a, neg_b, first, ge, div0;

  assign neg_a = mdu_signed(op) & a[XLEN-1];
  assign neg_b = mdu_signed(op) & b[XLEN-1];
  assign ma    = neg_a ? -a : a;
  assign mb    = neg_b ? -b : b;
  assign first = (cnt == '0);

  // Step 0 seeds from the magnitudes directly, so the working registers
  // are only ever written while iterating.
  assign p_in  = first ? {{XLEN{1'b0}}, mb} : p_q;
  assign psum  = {1'b0, p_in[2*XLEN-1:XLEN]} + {1'b0, (p_in[0] ? ma : {XLEN{1'b0}})};
  assign p_nxt = {psum, p_in[XLEN-1:1]};

  assign r_in  = first ? {XLEN{1'b0}} : r_q;
  assign q_in  = first ? ma : q_q;
  assign r_sh  = {r_in, q_in[XLEN-1]};
  assign ge    = (r_sh >= {1'b0, mb});
  assign r_sub = r_sh[XLEN-1:0] - mb;
  assign r_nxt = ge ? r_sub : r_sh[XLEN-1:0];
  assign q_nxt = {q_in[XLEN-2:0], ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      p_q   <= '0;
      r_q   <= '0;
      q_q   <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          p_q <= p_nxt;
          r_q <= r_nxt;
          q_q <= q_nxt;
          if (cnt == CNT_W'(XLEN-1)) begin
            state <= ST_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (ack) begin
            state <= start ? ST_RUN : ST_IDLE;
            cnt   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign prod = (neg_a ^ neg_b) ? -p_q : p_q;
  assign quo  = (neg_a ^ neg_b) ? -q_q : q_q;
  assign rem  = neg_a ? -r_q : r_q;
  assign div0 = (b == '0);

  // min / -1 falls out of the magnitude path; only divide-by-zero is patched.
  always_comb begin
    result = '0;
    case (op)
      MDU_MUL:            result = prod[XLEN-1:0];
      MDU_MULHU:          result = prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:  result = div0 ? {XLEN{1'b1}} : quo;
      MDU_REM, MDU_REMU:  result = div0 ? a : rem;
      default:            result = '0;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: rtl/ysyx_22040759_exe_mc.sv
// Execute stage wrapper: handshake, operand latch, single-cycle ALU,
// flush, forwarding, and hand-off of M-extension ops to the iterative MDU.
module ysyx_22040759_exe_mc
  import ysyx_22040759_exe_mc_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int PAYLOAD_W = 128
) (
  input logic                   clk,
  input logic                   rst,
  ysyx_22040759_exe_mc_if.slave bus
);
  localparam int SH_W = $clog2(XLEN);

  logic                 es_valid;
  op_t                  op_q;
  logic [XLEN-1:0]      a_q, b_q;
  logic [4:0]           rd_q;
  logic                 wen_q;
  logic [PAYLOAD_W-1:0] pay_q;

  logic                 ready_go, allowin, capture, ack;
  logic                 mdu_busy, mdu_done;
  logic [XLEN-1:0]      mdu_result, alu_result, result;
  logic [SH_W-1:0]      sh;

  assign ready_go = !is_mdu(op_q) | mdu_done;
  assign allowin  = !es_valid | (ready_go & bus.ms_allowin);
  assign capture  = bus.ds_to_es_valid & allowin & !bus.flush;
  assign ack      = es_valid & ready_go & bus.ms_allowin;

  always_ff @(posedge clk) begin
    if (rst) begin
      es_valid <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      pay_q    <= '0;
    end else begin
      if (bus.flush)
        es_valid <= 1'b0;
      else if (allowin)
        es_valid <= bus.ds_to_es_valid;
      if (capture) begin
        op_q  <= bus.ds_op;
        a_q   <= bus.ds_a;
        b_q   <= bus.ds_b;
        rd_q  <= bus.ds_rd;
        wen_q <= bus.ds_reg_wen;
        pay_q <= bus.ds_payload;
      end
    end
  end

  assign sh = b_q[SH_W-1:0];

  always_comb begin
    alu_result = '0;
    case (op_q)
      ALU_ADD:  alu_result = a_q + b_q;
      ALU_SUB:  alu_result = a_q - b_q;
      ALU_AND:  alu_result = a_q & b_q;
      ALU_OR:   alu_result = a_q | b_q;
      ALU_XOR:  alu_result = a_q ^ b_q;
      ALU_SLL:  alu_result = a_q << sh;
      ALU_SRL:  alu_result = a_q >> sh;
      ALU_SRA:  alu_result = $signed(a_q) >>> sh;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (a_q < b_q)};
      default:  alu_result = '0;
    endcase
  end

  // The MDU reads the latched operands, which stay put until the op leaves.
  ysyx_22040759_iter_mdu #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .flush  (bus.flush),
    .start  (capture & is_mdu(bus.ds_op)),
    .ack    (ack),
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .result (mdu_result)
  );

  assign result = is_mdu(op_q) ? mdu_result : alu_result;

  assign bus.es_allowin     = allowin;
  assign bus.es_to_ms_valid = es_valid & ready_go;
  assign bus.es_result      = result;
  assign bus.es_payload     = pay_q;
  assign bus.es_fwd_valid   = es_valid & wen_q & ready_go & (rd_q != 5'd0);
  assign bus.es_fwd_rd      = rd_q;
  assign bus.es_fwd_data    = result;
  assign bus.es_busy        = mdu_busy;

endmodule

// File: tb/tb_ysyx_22040759_exe_mc.sv
// Self-checking bench for ysyx_22040759_exe_mc: directed edge cases followed
// by a randomized stream scored against an arithmetic reference model.
module tb_ysyx_22040759_exe_mc;
  localparam int XLEN = 64;
  localparam int PW   = 128;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22040759_exe_mc_if #(.XLEN(XLEN), .PAYLOAD_W(PW)) bus ();
  ysyx_22040759_exe_mc #(.XLEN(XLEN), .PAYLOAD_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: stage occupancy plus the instruction currently held.
  bit          m_valid = 0;
  int          m_left  = 0;
  logic [63:0] m_res   = '0;
  logic [127:0] m_pay  = '0;
  logic [4:0]  m_rd    = '0;
  bit          m_wen   = 0;

  function automatic logic [63:0] ref_op(input logic [4:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
    logic [127:0] p;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << b[5:0];
      5'd6:  return a >> b[5:0];
      5'd7:  return $signed(a) >>> b[5:0];
      5'd8:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      5'd9:  return (a < b) ? 64'd1 : 64'd0;
      5'd16: return a * b;
      5'd17: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      5'd18: begin
        if (b == 64'd0) return '1;
        if (a == MINV && b == '1) return MINV;
        return $signed(a) / $signed(b);
      end
      5'd19: return (b == 64'd0) ? '1 : a / b;
      5'd20: begin
        if (b == 64'd0) return a;
        if (a == MINV && b == '1) return 64'd0;
        return $signed(a) % $signed(b);
      end
      5'd21: return (b == 64'd0) ? a : a % b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return MINV;
      3: return 64'($urandom_range(0, 20));
      4: return -64'($urandom_range(1, 20));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ins(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic wen);
    bus.ds_to_es_valid = 1'b1;
    bus.ds_op      = op;
    bus.ds_a       = a;
    bus.ds_b       = b;
    bus.ds_rd      = rd;
    bus.ds_reg_wen = wen;
    bus.ds_payload = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Called just after a falling edge with inputs set: score outputs against
  // the reference, advance one clock, return at the next falling edge.
  bit took;
  task automatic step();
    bit rdy, alw, nv;
    int nl;
    #1;
    rdy = (m_left == 0);
    alw = !m_valid || (rdy && bus.ms_allowin);
    if (!rst) begin
      chk("allowin", bus.es_allowin, alw);
      chk("to_ms_valid", bus.es_to_ms_valid, m_valid && rdy);
      chk("busy", bus.es_busy, m_valid && (m_left > 0));
      chk("fwd_valid", bus.es_fwd_valid, m_valid && rdy && m_wen && (m_rd != 5'd0));
      if (m_valid && rdy) begin
        chk("result", bus.es_result, m_res);
        chk("payload", bus.es_payload, m_pay);
        chk("fwd_data", bus.es_fwd_data, m_res);
        chk("fwd_rd", bus.es_fwd_rd, m_rd);
      end
    end
    took = 0;
    nv = m_valid;
    nl = m_left;
    if (rst) begin
      nv = 0; nl = 0;
      m_res = '0; m_pay = '0; m_rd = '0; m_wen = 0;
    end else if (bus.flush) begin
      nv = 0; nl = 0;
    end else if (alw) begin
      nv = bus.ds_to_es_valid;
      if (bus.ds_to_es_valid) begin
        took  = 1;
        m_res = ref_op(bus.ds_op, bus.ds_a, bus.ds_b);
        m_pay = bus.ds_payload;
        m_rd  = bus.ds_rd;
        m_wen = bus.ds_reg_wen;
        nl    = bus.ds_op[4] ? XLEN : 0;
      end
    end else if (m_left > 0) begin
      nl = m_left - 1;
    end
    @(posedge clk);
    m_valid = nv;
    m_left  = nl;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input logic [63:0] exp);
    int lat = 0;
    while (!bus.es_to_ms_valid && lat < 100) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 64);
    chk(tag, bus.es_result, exp);
  endtask

  task automatic run_mdu(input string tag, input logic [4:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
    set_ins(op, a, b, 5'd9, 1'b1);
    step();
    bus.ds_to_es_valid = 1'b0;
    wait_done(tag, exp);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    bus.flush = 1'b0;
    bus.ds_to_es_valid = 1'b0;
    bus.ds_op = '0; bus.ds_a = '0; bus.ds_b = '0; bus.ds_rd = '0;
    bus.ds_reg_wen = 1'b0; bus.ds_payload = '0;
    bus.ms_allowin = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_to_ms_valid", bus.es_to_ms_valid, 0);
    chk("rst_allowin", bus.es_allowin, 1);
    chk("rst_busy", bus.es_busy, 0);
    chk("rst_fwd_valid", bus.es_fwd_valid, 0);
    chk("rst_result", bus.es_result, 64'd0);
    chk("rst_payload", bus.es_payload, 128'd0);

    // ALU streaming with forwarding
    set_ins(5'd0, 64'd5, 64'd7, 5'd5, 1'b1);
    step();
    set_ins(5'd1, 64'd3, 64'd5, 5'd0, 1'b1);
    chk("add_result", bus.es_result, 64'd12);
    chk("add_fwd_valid", bus.es_fwd_valid, 1);
    chk("add_fwd_rd", bus.es_fwd_rd, 5'd5);
    step();
    set_ins(5'd7, MINV, 64'd4, 5'd6, 1'b1);
    chk("sub_result", bus.es_result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("rd0_fwd_valid", bus.es_fwd_valid, 0);
    step();
    bus.ds_to_es_valid = 1'b0;
    chk("sra_result", bus.es_result, 64'hF800_0000_0000_0000);
    chk("sra_to_ms_valid", bus.es_to_ms_valid, 1);
    step();

    // MUL then back-to-back MULHU captured on the DONE handshake
    set_ins(5'd16, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd7, 1'b1);
    step();
    bus.ds_to_es_valid = 1'b0;
    chk("mul_fwd_in_run", bus.es_fwd_valid, 0);
    wait_done("mul", 64'hFFFF_FFFE_0000_0001);
    set_ins(5'd17, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd7, 1'b1);
    step();
    bus.ds_to_es_valid = 1'b0;
    chk("mulhu_b2b_busy", bus.es_busy, 1);
    wait_done("mulhu", 64'd0);
    step();

    // Divide edge cases
    run_mdu("div_neg", 5'd18, -64'd7, 64'd2, -64'd3);
    run_mdu("rem_neg", 5'd20, -64'd7, 64'd2, -64'd1);
    run_mdu("divu_zero", 5'd19, 64'h1234_5678, 64'd0, '1);
    run_mdu("remu_zero", 5'd21, 64'h1234_5678, 64'd0, 64'h1234_5678);
    run_mdu("div_ovf", 5'd18, MINV, '1, MINV);
    run_mdu("rem_ovf", 5'd20, MINV, '1, 64'd0);

    // Backpressure in DONE, then release with a DIVU already waiting
    set_ins(5'd19, 64'd100, 64'd7, 5'd4, 1'b1);
    step();
    bus.ds_to_es_valid = 1'b0;
    wait_done("bp_divu", 64'd14);
    bus.ms_allowin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_result_hold", bus.es_result, 64'd14);
      chk("bp_payload_hold", bus.es_payload, m_pay);
    end
    set_ins(5'd19, 64'd1000, 64'd10, 5'd4, 1'b1);
    bus.ms_allowin = 1'b1;
    step();
    bus.ds_to_es_valid = 1'b0;
    chk("b2b_busy", bus.es_busy, 1);
    chk("b2b_allowin", bus.es_allowin, 0);
    wait_done("b2b_divu", 64'd100);
    step();

    // Flush at RUN cnt=20 with ID holding a valid instruction
    set_ins(5'd16, 64'd3, 64'd5, 5'd8, 1'b1);
    step();
    repeat (20) step();
    bus.flush = 1'b1;
    set_ins(5'd0, 64'd1, 64'd1, 5'd3, 1'b1);
    step();
    bus.flush = 1'b0;
    bus.ds_to_es_valid = 1'b0;
    chk("flush_to_ms_valid", bus.es_to_ms_valid, 0);
    chk("flush_busy", bus.es_busy, 0);
    chk("flush_allowin", bus.es_allowin, 1);
    step();
    chk("flush_not_captured", bus.es_to_ms_valid, 0);

    // Reset at RUN cnt=10
    set_ins(5'd18, 64'd99, 64'd3, 5'd8, 1'b1);
    step();
    repeat (10) step();
    rst = 1'b1;
    set_ins(5'd0, 64'd2, 64'd2, 5'd3, 1'b1);
    step();
    rst = 1'b0;
    bus.ds_to_es_valid = 1'b0;
    #1;
    chk("rst_run_valid", bus.es_to_ms_valid, 0);
    chk("rst_run_busy", bus.es_busy, 0);
    chk("rst_run_result", bus.es_result, 64'd0);
    chk("rst_run_payload", bus.es_payload, 128'd0);
    step();

    // Randomized stream with backpressure and occasional flush
    took = 0;
    for (int i = 0; i < 2500; i++) begin
      if (!bus.ds_to_es_valid || took) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.ds_to_es_valid = 1'b0;
        end else begin
          if ($urandom_range(0, 9) < 8) op = 5'($urandom_range(0, 9));
          else op = 5'(16 + $urandom_range(0, 5));
          set_ins(op, rnd_val(), rnd_val(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
      end
      bus.ms_allowin = ($urandom_range(0, 3) != 0);
      bus.flush = ($urandom_range(0, 63) == 0);
      step();
    end
    bus.flush = 1'b0;
    bus.ds_to_es_valid = 1'b0;
    bus.ms_allowin = 1'b1;
    repeat (70) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
